grill_draw_scheduler: RTL and testbench
=======================================

// Module: grill_draw_scheduler
// PURPOSE
//  Sequences the grill: drives the shared cook-phase level that advances every steak
//  doneness FSM, and arbitrates NUM_SLOTS steak slots onto the single VGA plotter.
//  Each slot's {muscle,fat} colour pair is compared against the last-drawn copy.
//  Changed slots are granted round-robin, one plotter draw at a time (req/ack).
//  Sits between the per-slot doneness controllers and the plotter datapath.
// PARAMETERS
//  NUM_SLOTS    4    number of steak slots (2..8)
//  TICK_DIV     50000000  clk cycles per cook_phase half-period (>=2)
//  X_BASE       8'd0  x origin of slot 0
//  SLOT_X_STEP  8'd40 x pitch between slots
//  SLOT_Y       7'd60 y origin of every slot
// PORTS
//  clk          in   1              system clock
//  resetn       in   1              synchronous active-low reset
//  cook_enable  in   1              1 = cook timer runs; 0 = hold
//  slot_colours in   18*NUM_SLOTS   slot i at [18i+17:18i] = {muscle[8:0],fat[8:0]}
//  draw_ack     in   1              plotter done; valid only while draw_req=1
//  cook_phase   out  1              level fed to every doneness FSM's clock input
//  draw_req     out  1              draw request, held until ack
//  draw_slot    out  3              granted slot index
//  draw_x       out  8              X_BASE + draw_slot*SLOT_X_STEP, mod 256
//  draw_y       out  7              SLOT_Y
//  draw_muscle  out  9              latched muscle colour of granted slot
//  draw_fat     out  9              latched fat colour of granted slot
//  busy         out  1              1 whenever FSM not in S_IDLE
// BEHAVIOUR
//  Reset (resetn=0 at posedge): tick_cnt=0, cook_phase=0, draw_req=0, busy=0,
//   draw_slot=0, draw_x=X_BASE, draw_y=SLOT_Y, draw_muscle=draw_fat=0, rr_ptr=0.
//   shadow[i]=0, force[i]=1 for all i (a full redraw follows every reset).
//   Applies mid-draw too: draw_req low after that edge; pending draw is abandoned.
//  Cook timer: if cook_enable, tick_cnt increments; at TICK_DIV-1 it wraps to 0
//   and cook_phase toggles on the same edge. cook_enable=0 holds both values.
//  dirty[i] = force[i] | (slot_colours[i] != shadow[i]), combinational.
//  FSM: S_IDLE, S_REQ, S_GAP.
//   S_IDLE: if any dirty, pick the first dirty slot scanning rr_ptr, rr_ptr+1, ...
//    (mod NUM_SLOTS). On that edge latch draw_slot/x/y/muscle/fat from the
//    current inputs, set draw_req=1, go S_REQ. No dirty: stay.
//   S_REQ: draw_req=1 and outputs stable. On edge with draw_ack=1:
//    shadow[slot]<=latched colours, force[slot]<=0, rr_ptr<=(slot+1) mod N,
//    draw_req<=0, go S_GAP. Ack in the cycle req first rises is legal.
//   S_GAP: one cycle, draw_req=0, then S_IDLE (ack in S_GAP/S_IDLE ignored).
//  Latency: input change visible before edge k with FSM idle -> draw_req=1 after k.
//   Back-to-back draws: min 3 cycles per slot (REQ+ack, GAP, IDLE).
//  Slot changes while its draw is pending: latched value is drawn and stored in
//   shadow, so the slot remains dirty and is redrawn with the new value later.
//  Multiple changes: one draw per grant; a slot is never granted twice in a row
//   while another slot is dirty (round-robin fairness).
//  Width: draw_x computed in 8 bits, overflow wraps; NUM_SLOTS>8 unsupported.
// TESTING (N=4, TICK_DIV=4, ack bench replies 2 cycles after req rises)
//  1 Reset, all colours 0 -> four draws slots 0,1,2,3, draw_x 0,40,80,120, y=60;
//    then busy=0 and draw_req stays 0.
//  2 Idle with rr_ptr=2; slots 0,1,3 change together -> grants 3,0,1 in order, each
//    carrying that slot's new {muscle,fat}.
//  3 Slot 2 changes 9'h1C0->9'h038 while its req is pending -> drawn with 9'h1C0,
//    then redrawn with 9'h038; no third draw.
//  4 cook_enable=1 -> cook_phase toggles every 4 clks; enable low 10 clks -> phase and
//    count frozen, resume continues from held count.
//  5 resetn low for 1 clk during S_REQ of slot 2 -> draw_req=0 next cycle; full
//    redraw restarts at slot 0; cook_phase=0.
//  6 draw_ack pulsed while idle / in S_GAP -> no state, shadow or rr_ptr change.

Source files
------------

// File: rtl/grill_draw_scheduler.sv
// ============================================================================
// grill_draw_scheduler: cook-phase timer plus round-robin arbitration of the
// steak slots onto the single plotter (req/ack). Rev 1.0
// ============================================================================
`default_nettype none

module grill_draw_scheduler #(
  parameter int         NUM_SLOTS   = 4,
  parameter int         TICK_DIV    = 50000000,
  parameter logic [7:0] X_BASE      = 8'd0,
  parameter logic [7:0] SLOT_X_STEP = 8'd40,
  parameter logic [6:0] SLOT_Y      = 7'd60
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cook_enable,
  input  logic [18*NUM_SLOTS-1:0] slot_colours,
  input  logic                    draw_ack,
  output logic                    cook_phase,
  output logic                    draw_req,
  output logic [2:0]              draw_slot,
  output logic [7:0]              draw_x,
  output logic [6:0]              draw_y,
  output logic [8:0]              draw_muscle,
  output logic [8:0]              draw_fat,
  output logic                    busy
);

  localparam int               CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [2:0]       LAST_SLOT = 3'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       tick_cnt_q, tick_cnt_d;
  logic                   cook_phase_q, cook_phase_d;
  logic                   draw_req_q, draw_req_d;
  logic [2:0]             slot_q, slot_d;
  logic [2:0]             rr_ptr_q, rr_ptr_d;
  logic [7:0]             x_q, x_d;
  logic [8:0]             muscle_q, muscle_d;
  logic [8:0]             fat_q, fat_d;
  logic [17:0]            shadow_q [NUM_SLOTS];
  logic [17:0]            shadow_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]   force_redraw_q, force_redraw_d;

  logic [NUM_SLOTS-1:0]   dirty;
  logic                   any_hi, any_lo;
  logic [2:0]             idx_hi, idx_lo, pick;
  logic [17:0]            pick_colour;

  always_comb begin
    tick_cnt_d   = tick_cnt_q;
    cook_phase_d = cook_phase_q;
    if (cook_enable) begin
      if (tick_cnt_q == CNT_MAX) begin
        tick_cnt_d   = '0;
        cook_phase_d = ~cook_phase_q;
      end else begin
        tick_cnt_d = tick_cnt_q + CNT_W'(1);
      end
    end
  end

  // Descending scans leave the lowest matching index: idx_hi is the first
  // dirty slot at or after rr_ptr, idx_lo the wrap-around fallback.
  always_comb begin
    dirty       = '0;
    any_hi      = 1'b0;
    any_lo      = 1'b0;
    idx_hi      = '0;
    idx_lo      = '0;
    pick_colour = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      dirty[i] = force_redraw_q[i] | (slot_colours[18*i +: 18] != shadow_q[i]);
      if (dirty[i]) begin
        any_lo = 1'b1;
        idx_lo = 3'(i);
        if (3'(i) >= rr_ptr_q) begin
          any_hi = 1'b1;
          idx_hi = 3'(i);
        end
      end
    end
    pick = any_hi ? idx_hi : idx_lo;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (3'(i) == pick) pick_colour = slot_colours[18*i +: 18];
    end
  end

  always_comb begin
    state_d        = state_q;
    draw_req_d     = draw_req_q;
    slot_d         = slot_q;
    rr_ptr_d       = rr_ptr_q;
    x_d            = x_q;
    muscle_d       = muscle_q;
    fat_d          = fat_q;
    shadow_d       = shadow_q;
    force_redraw_d = force_redraw_q;
    case (state_q)
      S_IDLE: begin
        if (any_lo) begin
          slot_d              = pick;
          x_d                 = X_BASE + 8'(pick) * SLOT_X_STEP;
          {muscle_d, fat_d}   = pick_colour;
          draw_req_d          = 1'b1;
          state_d             = S_REQ;
        end
      end
      S_REQ: begin
        if (draw_ack) begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (3'(i) == slot_q) begin
              shadow_d[i]       = {muscle_q, fat_q};
              force_redraw_d[i] = 1'b0;
            end
          end
          rr_ptr_d   = (slot_q == LAST_SLOT) ? 3'd0 : slot_q + 3'd1;
          draw_req_d = 1'b0;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        draw_req_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        draw_req_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      tick_cnt_q     <= '0;
      cook_phase_q   <= 1'b0;
      draw_req_q     <= 1'b0;
      slot_q         <= '0;
      rr_ptr_q       <= '0;
      x_q            <= X_BASE;
      muscle_q       <= '0;
      fat_q          <= '0;
      shadow_q       <= '{default: '0};
      force_redraw_q <= '1;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      cook_phase_q   <= cook_phase_d;
      draw_req_q     <= draw_req_d;
      slot_q         <= slot_d;
      rr_ptr_q       <= rr_ptr_d;
      x_q            <= x_d;
      muscle_q       <= muscle_d;
      fat_q          <= fat_d;
      shadow_q       <= shadow_d;
      force_redraw_q <= force_redraw_d;
    end
  end

  assign cook_phase  = cook_phase_q;
  assign draw_req    = draw_req_q;
  assign draw_slot   = slot_q;
  assign draw_x      = x_q;
  assign draw_y      = SLOT_Y;
  assign draw_muscle = muscle_q;
  assign draw_fat    = fat_q;
  assign busy        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_grill_draw_scheduler.sv
// ============================================================================
// tb_grill_draw_scheduler: directed bench with an expected-draw queue and an
// auto-ack plotter model replying two cycles after each request. Rev 1.0
// ============================================================================
`default_nettype none

module tb_grill_draw_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cook_enable;
  logic [71:0] colours;
  logic        ack_auto = 1'b0;
  logic        ack_manual;
  logic        draw_ack;
  logic        cook_phase, draw_req, busy;
  logic [2:0]  draw_slot;
  logic [7:0]  draw_x;
  logic [6:0]  draw_y;
  logic [8:0]  draw_muscle, draw_fat;

  typedef struct packed {
    logic [2:0] slot;
    logic [8:0] muscle;
    logic [8:0] fat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   req_cnt = 0;

  assign draw_ack = ack_auto | ack_manual;

  always #5 clk = ~clk;

  grill_draw_scheduler #(
    .NUM_SLOTS(4), .TICK_DIV(4), .X_BASE(8'd0), .SLOT_X_STEP(8'd40), .SLOT_Y(7'd60)
  ) dut (
    .clk(clk), .resetn(resetn), .cook_enable(cook_enable), .slot_colours(colours),
    .draw_ack(draw_ack), .cook_phase(cook_phase), .draw_req(draw_req),
    .draw_slot(draw_slot), .draw_x(draw_x), .draw_y(draw_y),
    .draw_muscle(draw_muscle), .draw_fat(draw_fat), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t exp_of(input int i);
    logic [17:0] c;
    c = colours[18*i +: 18];
    return {3'(i), c[17:9], c[8:0]};
  endfunction

  task automatic set_slot(input int i, input logic [8:0] m, input logic [8:0] f);
    colours[18*i +: 18] = {m, f};
  endtask

  // Plotter model and scoreboard pop on the first cycle of each request.
  always @(negedge clk) begin
    if (draw_req) begin
      req_cnt = req_cnt + 1;
      if (req_cnt == 1) begin
        if (sb.size() == 0) begin
          chk("unexpected_draw_slot", 32'(draw_slot), 32'hFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("draw_slot", 32'(draw_slot), 32'(e.slot));
          chk("draw_x", 32'(draw_x), 32'(8'(e.slot * 40)));
          chk("draw_y", 32'(draw_y), 32'd60);
          chk("draw_muscle", 32'(draw_muscle), 32'(e.muscle));
          chk("draw_fat", 32'(draw_fat), 32'(e.fat));
          chk("busy_in_req", 32'(busy), 32'd1);
        end
      end
      ack_auto = (req_cnt == 2);
    end else begin
      req_cnt  = 0;
      ack_auto = 1'b0;
    end
  end

  task automatic wait_drained(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy || draw_req) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_timeout"}, 32'(n < 300), 32'd1);
    repeat (6) @(negedge clk);
    chk({tag, "_req_quiet"}, 32'(draw_req), 32'd0);
    chk({tag, "_busy_quiet"}, 32'(busy), 32'd0);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!draw_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req_timeout"}, 32'(draw_req), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn      = 1'b0;
    cook_enable = 1'b0;
    colours     = '0;
    ack_manual  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(draw_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_slot", 32'(draw_slot), 32'd0);
    chk("rst_x", 32'(draw_x), 32'd0);
    chk("rst_y", 32'(draw_y), 32'd60);
    chk("rst_muscle", 32'(draw_muscle), 32'd0);
    chk("rst_fat", 32'(draw_fat), 32'd0);
    chk("rst_phase", 32'(cook_phase), 32'd0);

    // Full redraw after reset
    for (int i = 0; i < 4; i++) sb.push_back(exp_of(i));
    resetn = 1'b1;
    wait_drained("t1");

    // Move rr_ptr to 2 via a slot-1 draw, checking one-edge latency
    set_slot(1, 9'h011, 9'h022);
    sb.push_back(exp_of(1));
    @(negedge clk);
    chk("t2_latency_req", 32'(draw_req), 32'd1);
    wait_drained("t2a");
    set_slot(0, 9'h101, 9'h0F0);
    set_slot(1, 9'h0AB, 9'h1CD);
    set_slot(3, 9'h1FF, 9'h003);
    sb.push_back(exp_of(3));
    sb.push_back(exp_of(0));
    sb.push_back(exp_of(1));
    wait_drained("t2b");

    // Change while pending: old value drawn, then redrawn once
    set_slot(2, 9'h1C0, 9'h005);
    sb.push_back(exp_of(2));
    wait_req("t3");
    set_slot(2, 9'h038, 9'h005);
    sb.push_back(exp_of(2));
    wait_drained("t3");

    // Cook timer
    cook_enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_phase_3", 32'(cook_phase), 32'd0);
    @(negedge clk);
    chk("t4_phase_4", 32'(cook_phase), 32'd1);
    repeat (3) @(negedge clk);
    chk("t4_phase_7", 32'(cook_phase), 32'd1);
    @(negedge clk);
    chk("t4_phase_8", 32'(cook_phase), 32'd0);
    repeat (2) @(negedge clk);
    cook_enable = 1'b0;
    repeat (10) @(negedge clk);
    chk("t4_phase_hold", 32'(cook_phase), 32'd0);
    cook_enable = 1'b1;
    @(negedge clk);
    chk("t4_resume_1", 32'(cook_phase), 32'd0);
    @(negedge clk);
    chk("t4_resume_2", 32'(cook_phase), 32'd1);
    cook_enable = 1'b0;

    // Reset during S_REQ of slot 2
    set_slot(2, 9'h0AA, 9'h055);
    sb.push_back(exp_of(2));
    wait_req("t5");
    resetn = 1'b0;
    @(negedge clk);
    chk("t5_req_low", 32'(draw_req), 32'd0);
    chk("t5_busy_low", 32'(busy), 32'd0);
    chk("t5_phase", 32'(cook_phase), 32'd0);
    for (int i = 0; i < 4; i++) sb.push_back(exp_of(i));
    resetn = 1'b1;
    wait_drained("t5");

    // Stray acks while idle
    ack_manual = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_idle_req", 32'(draw_req), 32'd0);
      chk("t6_idle_busy", 32'(busy), 32'd0);
    end
    ack_manual = 1'b0;

    // Stray ack in S_GAP, then confirm rr_ptr advanced only once (to 2)
    set_slot(1, 9'h123, 9'h045);
    sb.push_back(exp_of(1));
    begin
      int n = 0;
      while (!ack_auto && n < 50) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("t6_ack_timeout", 32'(ack_auto), 32'd1);
    end
    @(posedge clk);
    #1;
    chk("t6_gap_req", 32'(draw_req), 32'd0);
    chk("t6_gap_busy", 32'(busy), 32'd1);
    ack_manual = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    ack_manual = 1'b0;
    wait_drained("t6a");
    set_slot(0, 9'h0E1, 9'h0E2);
    set_slot(2, 9'h0E3, 9'h0E4);
    sb.push_back(exp_of(2));
    sb.push_back(exp_of(0));
    wait_drained("t6b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
